// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet layout and port/source-ID sizing.
package noc_pkg;

  localparam int PKT_W  = 8;
  localparam int ADDR_W = 4;
  localparam int NPORT  = 16;
  // A source ID must index every input port.
  localparam int SRC_W  = 4;

  // Packet layout as it travels on the network: payload nibble over address nibble.
  typedef struct packed {
    logic [3:0] data;
    logic [3:0] addr;
  } pkt_t;

endpackage

// File: rtl/rr_arbiter16.sv
// 16-way round-robin priority select. Purely combinational: the search
// starts one past last_grant and wraps, so the most recent winner has the
// lowest priority on the next pick.
module rr_arbiter16
  import noc_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [SRC_W-1:0] last_grant,
  output logic [NPORT-1:0] grant,
  output logic [SRC_W-1:0] grant_idx,
  output logic             any_grant
);

  // Scan ports in rotated order and latch onto the first requester.
  always_comb begin
    logic [SRC_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NPORT; k++) begin
      // k == NPORT wraps back to last_grant itself (lowest priority).
      cand = last_grant + SRC_W'(k);
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        grant_idx = cand;
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/noc_merge16.sv
// 16-to-1 NoC merge: round-robin picks one input per cycle into a single
// output register, tagging each packet with the port it came from.
//
// Handshake: every port (each input and the output) uses valid/ready.
// A beat transfers on a rising clk edge where valid and ready are both high.
// A sender holds its packet stable while valid is high and unaccepted; ready
// here never depends on the data, only on valid, arbitration state and the
// output register occupancy.
module noc_merge16
  import noc_pkg::*;
#(
  parameter int WIDTH = 8,
  // Fixed at 16: the arbiter and the 4-bit source tag assume it.
  parameter int NPORT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPORT-1:0]             in_valid,
  input  logic [NPORT-1:0][WIDTH-1:0]  in_data,
  output logic [NPORT-1:0]             in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [SRC_W-1:0]             out_src,
  input  logic                         out_ready,
  output logic [15:0]                  pkt_count
);

  logic [SRC_W-1:0] last_grant;
  logic [NPORT-1:0] grant;
  logic [SRC_W-1:0] grant_idx;
  logic             any_grant;
  logic             load_ok;
  logic             load;

  rr_arbiter16 u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  // Slot is free when empty or draining this same edge, which is what lets
  // the merge run at one packet per cycle.
  assign load_ok = !out_valid || out_ready;
  assign load    = load_ok && any_grant;

  // Ready goes only to the winner; held low throughout reset.
  assign in_ready = (rst_n && load_ok) ? grant : '0;

  // Output register, arbitration pointer and accepted-packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SRC_W'(NPORT - 1);
      pkt_count  <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[grant_idx];
      out_src    <= grant_idx;
      last_grant <= grant_idx;
      pkt_count  <= pkt_count + 16'd1;
    end else if (load_ok) begin
      // Drained with nothing to refill; pointer stays where it was.
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_merge16.sv
// Self-checking bench for noc_merge16: directed scenarios plus a randomized
// scoreboard run against an independent round-robin reference model.
module tb_noc_merge16;

  localparam int W = 8;
  localparam int N = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         in_valid;
  logic [N-1:0][W-1:0]  in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic [3:0]           out_src;
  logic                 out_ready;
  logic [15:0]          pkt_count;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {src[3:0], data[7:0]}
  logic [11:0] exp_q[$];

  noc_merge16 #(.WIDTH(W), .NPORT(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .pkt_count (pkt_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = 8'($urandom);
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++; if (out_src !== 4'h0) begin errors++; $display("FAIL reset_out_src got %h exp 0", out_src); end
    checks++; if (pkt_count !== 16'h0000) begin errors++; $display("FAIL reset_pkt_count got %h exp 0000", pkt_count); end
    checks++; if (in_ready !== 16'h0000) begin errors++; $display("FAIL reset_in_ready got %h exp 0000", in_ready); end
  endtask

  task automatic test_single();
    in_valid    = 16'h0020;
    in_data[5]  = 8'hA3;
    out_ready   = 1'b1;
    #1;
    checks++; if (in_ready !== 16'h0020) begin errors++; $display("FAIL single_in_ready got %h exp 0020", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'hA3) begin errors++; $display("FAIL single_out_data got %h exp a3", out_data); end
    checks++; if (out_src !== 4'd5) begin errors++; $display("FAIL single_out_src got %0d exp 5", out_src); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt_count got %0d exp 1", pkt_count); end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_rotation();
    logic [11:0] e;
    do_reset();
    for (int i = 0; i < N; i++) in_data[i] = 8'(i * 17) ^ 8'h5A;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back({4'(k % 16), 8'((k % 16) * 17) ^ 8'h5A});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || {out_src, out_data} !== e) begin
        errors++; $display("FAIL rotation_step%0d got v=%b src=%0d data=%h exp src=%0d data=%h",
                           k, out_valid, out_src, out_data, e[11:8], e[7:0]);
      end
    end
    checks++; if (pkt_count !== 16'd17) begin errors++; $display("FAIL rotation_pkt_count got %0d exp 17", pkt_count); end
  endtask

  // Follows test_rotation: output holds port 0's packet, last grant is 0.
  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (in_ready !== 16'h0000) begin errors++; $display("FAIL stall%0d_in_ready got %h exp 0000", k, in_ready); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || out_src !== 4'd0 || out_data !== (8'h00 ^ 8'h5A)) begin
        errors++; $display("FAIL stall%0d_hold got v=%b src=%0d data=%h exp v=1 src=0 data=5a", k, out_valid, out_src, out_data);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 16'h0002) begin errors++; $display("FAIL resume_in_ready got %h exp 0002", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_src !== 4'd1 || out_data !== (8'd17 ^ 8'h5A)) begin
      errors++; $display("FAIL resume_load got v=%b src=%0d data=%h exp v=1 src=1 data=%h", out_valid, out_src, out_data, 8'd17 ^ 8'h5A);
    end
    checks++; if (pkt_count !== 16'd18) begin errors++; $display("FAIL resume_pkt_count got %0d exp 18", pkt_count); end
  endtask

  task automatic test_alternate();
    logic [11:0] e;
    do_reset();
    in_data[3]  = 8'h33;
    in_data[12] = 8'hCC;
    out_ready   = 1'b1;
    in_valid    = 16'(1) << 3;
    @(posedge clk);
    #1;
    @(negedge clk);
    in_valid = (16'(1) << 3) | (16'(1) << 12);
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? {4'd12, 8'hCC} : {4'd3, 8'h33};
      exp_q.push_back(e);
      #1;
      checks++; if (in_ready !== (16'(1) << e[11:8])) begin
        errors++; $display("FAIL alt%0d_in_ready got %h exp %h", k, in_ready, 16'(1) << e[11:8]);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++; if ({out_src, out_data} !== e) begin
        errors++; $display("FAIL alt%0d_out got src=%0d data=%h exp src=%0d data=%h", k, out_src, out_data, e[11:8], e[7:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    in_valid  = '1;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b exp 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %b exp 0", out_valid); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL areset_pkt_count got %0d exp 0", pkt_count); end
    checks++; if (in_ready !== 16'h0000) begin errors++; $display("FAIL areset_in_ready got %h exp 0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 16'h0001) begin errors++; $display("FAIL areset_first_ready got %h exp 0001", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_src !== 4'd0) begin
      errors++; $display("FAIL areset_first_grant got v=%b src=%0d exp v=1 src=0", out_valid, out_src);
    end
  endtask

  task automatic test_random();
    logic [7:0]  src_q[N][$];
    logic [11:0] e;
    logic [N-1:0] exp_rdy;
    int remaining, m_last, w, cyc;
    bit m_ov, m_load_ok, found;
    do_reset();
    for (int n = 0; n < 1000; n++) src_q[$urandom_range(0, N - 1)].push_back(8'($urandom));
    remaining = 1000;
    m_last = 15;
    m_ov = 1'b0;
    cyc = 0;
    while ((remaining > 0 || m_ov) && cyc < 20000) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i] = (src_q[i].size() > 0) && ($urandom_range(0, 3) != 0);
        in_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      // reference round-robin pick
      m_load_ok = !m_ov || out_ready;
      found = 1'b0;
      w = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && in_valid[(m_last + k) % N]) begin
          found = 1'b1;
          w = (m_last + k) % N;
        end
      end
      exp_rdy = (m_load_ok && found) ? (16'(1) << w) : 16'h0000;
      checks++; if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_c%0d_in_ready got %h exp %h", cyc, in_ready, exp_rdy);
      end
      checks++; if (out_valid !== m_ov) begin
        errors++; $display("FAIL rand_c%0d_out_valid got %b exp %b", cyc, out_valid, m_ov);
      end
      if (m_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_c%0d_underflow got output with empty scoreboard exp none", cyc);
        end else begin
          e = exp_q.pop_front();
          checks++; if ({out_src, out_data} !== e) begin
            errors++; $display("FAIL rand_c%0d_pkt got src=%0d data=%h exp src=%0d data=%h", cyc, out_src, out_data, e[11:8], e[7:0]);
          end
        end
      end
      if (m_load_ok && found) begin
        exp_q.push_back({4'(w), src_q[w].pop_front()});
        remaining--;
        m_last = w;
        m_ov = 1'b1;
      end else if (m_load_ok) begin
        m_ov = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = '0;
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout got %0d cycles exp < 20000", cyc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d entries exp 0", exp_q.size()); end
    checks++; if (pkt_count !== 16'd1000) begin errors++; $display("FAIL rand_pkt_count got %0d exp 1000", pkt_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid  = '1;
    out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (pkt_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h exp ffff", pkt_count); end
    @(posedge clk);
    #1;
    checks++; if (pkt_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", pkt_count); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    do_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_alternate();
    test_async_reset();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_merge16.md
NOC_MERGE16 -- requirements
Module: noc_merge16

Interface
REQ-001 Parameter WIDTH, default 8, packet width in bits ({data[7:4], addr[3:0]}).
REQ-002 Parameter NPORT, default 16, number of input ports; fixed at 16 so a source ID fits in 4 bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  NPORT  per-port packet-present flag.
REQ-007 in_data  input  NPORT x WIDTH  per-port packet.
REQ-008 in_ready  output  NPORT  per-port accept; a transfer occurs on port i when in_valid[i] and in_ready[i] are both high at a clk edge.
REQ-009 out_valid  output  1  output register holds a packet.
REQ-010 out_data  output  WIDTH  merged packet.
REQ-011 out_src  output  4  index of the input port the packet came from.
REQ-012 out_ready  input  1  downstream accept; a transfer occurs when out_valid and out_ready are both high at a clk edge.
REQ-013 pkt_count  output  16  count of packets accepted since reset.

Function
REQ-014 The block SHALL be the N-to-1 merge counterpart of the 1-to-16 split: it collects packets from 16 ports onto one output, tagged with their source.
REQ-015 load_ok = !out_valid || out_ready; this is the slot-free condition, and it SHALL allow a load in the same cycle the output register drains.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 16 and increases with wrap; the first port with in_valid high wins.
REQ-017 in_ready[i] SHALL be high only for the winning port and only when load_ok; at most one in_ready bit is high per cycle (one-hot or zero).
REQ-018 On a transfer, out_data <= in_data[winner], out_src <= winner, out_valid <= 1, last_grant <= winner, and pkt_count increments; latency is 1 cycle from input acceptance to out_valid.
REQ-019 If load_ok and no in_valid is high, out_valid <= 0 when draining; last_grant SHALL be unchanged.
REQ-020 If out_valid and !out_ready, out_data, out_src and out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-021 The block SHALL sustain one packet per cycle when out_ready is held high and any input is valid.
REQ-022 pkt_count SHALL wrap from 16'hFFFF to 0.
REQ-023 A packet SHALL NOT be dropped or duplicated; each accepted packet SHALL appear on the output exactly once.
REQ-024 in_ready SHALL be a combinational function of in_valid, last_grant, out_valid and out_ready; there SHALL be no path from in_data to in_ready.

Reset
REQ-025 While rst_n is low: out_valid = 0, out_data = 0, out_src = 0, pkt_count = 0, last_grant = 15 (so port 0 has first priority), and in_ready = 0.
REQ-026 An output packet in flight at reset assertion SHALL be discarded.
REQ-027 The first transfer is possible on the first clk edge after rst_n deasserts.

Structure
REQ-028 Shared package noc_pkg SHALL hold PKT_W = 8, ADDR_W = 4, NPORT = 16, and typedef pkt_t = {data[3:0], addr[3:0]}.
REQ-029 The round-robin priority select SHALL be one sub-module, rr_arbiter16 (inputs: request vector, last_grant; outputs: one-hot grant, grant index, any_grant).
REQ-030 All state (output register, last_grant, pkt_count) SHALL live in noc_merge16.

Verification
REQ-031 Reset, then raise in_valid[5] only with in_data = 8'hA3 and out_ready = 1 -> in_ready = 16'h0020 that cycle; the next cycle out_valid = 1, out_data = A3, out_src = 5, pkt_count = 1.
REQ-032 Hold all 16 in_valid high with out_ready = 1 for 17 cycles -> out_src sequence 0,1,...,15,0 on consecutive cycles, with no gaps.
REQ-033 Hold out_ready low for 4 cycles with a packet held -> out_data and out_src stay stable and in_ready = 0; then raise out_ready -> a new packet loads in the same cycle (back-to-back).
REQ-034 Ports 3 and 12 continuously valid, last_grant = 3 -> grants alternate 12, 3, 12, 3.
REQ-035 Assert rst_n low mid-stream with out_valid = 1 -> out_valid = 0 and pkt_count = 0 immediately (asynchronously); after release the first grant goes to port 0.
REQ-036 Scoreboard run of 1000 random packets on random ports with random out_ready -> the output multiset equals the input multiset, per-port order is preserved, and pkt_count = 1000.
